// File: rtl/start_debounce_ctrl.sv
// start_debounce_ctrl: turns a raw, bouncy push-button into a single-cycle
// 'go' start request. It waits for the downstream 'done' level, with a
// timeout, and re-arms only after a debounced release.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | armed, waiting for the synchronised button to go high
// DEB_PRESS | button high, counting stable samples before accepting press
// FIRE      | one-cycle go pulse, press counted
// WAIT_DONE | waiting for 'done' from downstream, bounded by timeout
// WAIT_REL  | waiting for a debounced release before re-arming
module start_debounce_ctrl #(
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 32,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_raw,
   input  logic       done,
   output logic       go,
   output logic       busy,
   output logic       timeout_err,
   output logic [7:0] press_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DEB_PRESS = 3'd1,
      FIRE      = 3'd2,
      WAIT_DONE = 3'd3,
      WAIT_REL  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             s1, btn_s;
   logic             to_set;
   logic             press_inc;

   // Two-flop synchroniser for the asynchronous button level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         s1    <= btn_raw;
         btn_s <= s1;
      end
   end

   // State, shared counter, sticky timeout flag and press counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         timeout_err <= 1'b0;
         press_count <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (to_set)
            timeout_err <= 1'b1;
         if (press_inc)
            press_count <= press_count + 8'd1;
      end
   end

   // Next-state and counter decisions; 'done' only matters in WAIT_DONE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      to_set    = 1'b0;
      press_inc = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = DEB_PRESS;
               cnt_nxt   = CNT_ONE;
            end
         end
         DEB_PRESS: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt = FIRE;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         FIRE: begin
            press_inc = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            // done has priority over the timeout limit in the same cycle
            if (done) begin
               state_nxt = WAIT_REL;
               cnt_nxt   = '0;
            end else if (cnt == TO_LAST) begin
               to_set    = 1'b1;
               state_nxt = WAIT_REL;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         WAIT_REL: begin
            if (btn_s) begin
               cnt_nxt = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs decoded from the state register only.
   always_comb begin
      go   = (state == FIRE);
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_start_debounce_ctrl.sv
// Directed bench for start_debounce_ctrl. Inputs change and outputs are
// sampled on the falling edge; every expected value is hand-computed.
module tb_start_debounce_ctrl;

   logic       clk;
   logic       rst_n;
   logic       btn_raw;
   logic       done;
   logic       go;
   logic       busy;
   logic       timeout_err;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;
   int go_seen = 0;
   int g0;

   start_debounce_ctrl #(
      .DEBOUNCE_CYCLES(8),
      .TIMEOUT_CYCLES (32),
      .CNT_W          (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .done       (done),
      .go         (go),
      .busy       (busy),
      .timeout_err(timeout_err),
      .press_count(press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance past one rising edge, land on the falling edge, tally go pulses
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (go === 1'b1) go_seen++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_raw = 1'b0;
      done    = 1'b0;
      tick(3);
      chk("rst_go", go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_count", press_count, 0);
      rst_n = 1'b1;
      tick(3);

      // press, go after 10 edges, done 3 cycles after go
      btn_raw = 1'b1;
      tick(2);
      chk("t1_busy_k1", busy, 0);
      tick(1);
      chk("t1_busy_k2", busy, 1);
      tick(6);
      chk("t1_go_early", go, 0);
      tick(1);
      chk("t1_go", go, 1);
      chk("t1_count_at_go", press_count, 0);
      tick(1);
      chk("t1_go_width", go, 0);
      chk("t1_count", press_count, 1);
      tick(1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(1);
      chk("t1_busy_rel", busy, 1);
      chk("t1_no_timeout", timeout_err, 0);

      // held button never retriggers; busy falls 10 edges after release
      g0 = go_seen;
      tick(50);
      chk("t3_no_retrigger", go_seen - g0, 0);
      btn_raw = 1'b0;
      tick(9);
      chk("t3_busy_before", busy, 1);
      tick(1);
      chk("t3_busy_after", busy, 0);
      tick(3);

      // done arriving exactly at the timeout limit wins
      btn_raw = 1'b1;
      tick(10);
      chk("t5_go", go, 1);
      tick(32);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      chk("t5_done_wins", timeout_err, 0);
      chk("t5_busy", busy, 1);
      tick(5);
      chk("t5_still_clear", timeout_err, 0);
      btn_raw = 1'b0;
      tick(10);
      chk("t5_idle", busy, 0);
      chk("t5_count", press_count, 2);
      tick(3);

      // bounce: 5 high, 1 low, then held; go timed from the last rise
      g0 = go_seen;
      btn_raw = 1'b1;
      tick(5);
      btn_raw = 1'b0;
      tick(1);
      btn_raw = 1'b1;
      tick(9);
      chk("t2_no_glitch_go", go_seen - g0, 0);
      tick(1);
      chk("t2_go", go, 1);
      // no done: timeout 33 edges after go
      tick(32);
      chk("t4_timeout_early", timeout_err, 0);
      tick(1);
      chk("t4_timeout", timeout_err, 1);
      chk("t2_single_go", go_seen - g0, 1);
      chk("t4_count", press_count, 3);
      tick(5);
      chk("t4_sticky", timeout_err, 1);
      btn_raw = 1'b0;
      tick(10);
      chk("t4_idle", busy, 0);
      chk("t4_sticky_idle", timeout_err, 1);
      tick(3);

      // next press still fires; then reset mid-WAIT_DONE between edges
      btn_raw = 1'b1;
      tick(10);
      chk("t4_go_again", go, 1);
      tick(1);
      chk("t4_count2", press_count, 4);
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_go", go, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_timeout", timeout_err, 0);
      chk("t6_rst_count", press_count, 0);
      btn_raw = 1'b0;
      tick(3);
      rst_n = 1'b1;
      g0 = go_seen;
      tick(20);
      chk("t6_no_go_after_rst", go_seen - g0, 0);
      chk("t6_idle", busy, 0);

      // 256 presses wrap the press counter
      g0 = go_seen;
      for (int p = 0; p < 256; p++) begin
         btn_raw = 1'b1;
         tick(12);
         done = 1'b1;
         tick(1);
         done = 1'b0;
         btn_raw = 1'b0;
         tick(11);
         if (p == 254) chk("t6_count_255", press_count, 255);
      end
      chk("t6_go_total", go_seen - g0, 256);
      chk("t6_wrap", press_count, 0);
      chk("t6_no_timeout", timeout_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
